trap_entry_sequencer: RTL and testbench
=======================================

Name: trap_entry_sequencer

Overview:
- Trap-entry side of the supervisor trap path; the counterpart of the sret return-PC forwarding logic.
- On an ecall or unimp detected in EX, serially writes sepc, scause and stval through the single CSR write port, stalling the pipeline meanwhile.
- Then issues a one-cycle redirect to the stvec base.
- Sits between the EX-stage trap detector and the CSR file / IF PC mux.

Parameters:
XLEN, 64, data/PC width
SCAUSE_ECALL, 8, scause code for ecall (from U-mode)
SCAUSE_ILLEGAL, 2, scause code for unimp (illegal instruction)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
trap_valid  input  1  trap request from EX
trap  input  2  00 none, 01 ecall, 10 unimp, 11 sret (11 and 00 not accepted here)
trap_pc  input  XLEN  PC of trapping instruction
trap_inst  input  32  trapping instruction word
trap_ready  output  1  high only in IDLE
stvec_value  input  XLEN  current stvec from CSR read port
sstatus_value  input  XLEN  current sstatus (used only with optional feature)
csr_write  output  1  CSR write enable
csr_write_addr  output  12  CSR write address
csr_write_data  output  XLEN  CSR write data
stall  output  1  freeze IF/ID/EX while sequencing
redirect_valid  output  1  one-cycle PC redirect + flush
redirect_pc  output  XLEN  redirect target

Behaviour:
- States: IDLE, W_SEPC, W_SCAUSE, W_STVAL, [W_SSTATUS], REDIRECT. Moore outputs decoded from the state and captured registers.
- Accept: in IDLE, if trap_valid && trap ∈ {01, 10}, latch the following and go to W_SEPC:
  - pc_q = trap_pc with bits[1:0] cleared.
  - cause_q = SCAUSE_ECALL for 01, SCAUSE_ILLEGAL for 10, zero-extended to XLEN.
  - tval_q = 0 for ecall; zero-extended trap_inst for unimp.
- Not accepted in IDLE: trap_valid with trap 00 or 11. Nothing happens.
- W_SEPC: csr_write=1, addr 12'h141, data pc_q. Next state W_SCAUSE.
- W_SCAUSE: csr_write=1, addr 12'h142, data cause_q. Next state W_STVAL.
- W_STVAL: csr_write=1, addr 12'h143, data tval_q. Next state REDIRECT, or W_SSTATUS when the feature is enabled.
- REDIRECT: redirect_valid=1, redirect_pc = stvec_value with bits[1:0] cleared (direct mode only; stvec_value sampled in this cycle). Next state IDLE.
- stall=1 in every non-IDLE state, including REDIRECT. stall=0 in IDLE.
- Latency: the accept edge is cycle 0.
  - Writes occur in cycles 1, 2, 3.
  - Redirect occurs in cycle 4 (cycle 5 with the feature).
  - trap_ready returns high in cycle 5 (6 with the feature).
- Outside the active state for each signal: csr_write=0, csr_write_addr=0, csr_write_data=0, redirect_valid=0, redirect_pc=0.
- Busy: trap_valid while not in IDLE is ignored. Captured values are not overwritten.
- Back-to-back: a new trap may be accepted on the first IDLE cycle after REDIRECT.
- Reset (any time, including mid-sequence): asynchronously return to IDLE; all captured registers cleared.
  - Outputs after reset: trap_ready=1, stall=0, csr_write=0, redirect_valid=0, all data/address outputs 0.
  - A partially written CSR set is not rolled back.
- No arithmetic beyond masking and zero-extension; all widths are XLEN except trap_inst.

Optional Feature:
- Macro: TRAP_SSTATUS_EN.
- Defined: adds state W_SSTATUS between W_STVAL and REDIRECT.
  - csr_write=1, addr 12'h100.
  - Data = sstatus_value with SPIE(bit 5) = old SIE(bit 1), SIE = 0, SPP(bit 8) = 0 (trap from U-mode); all other bits unchanged.
  - sstatus_value is sampled in W_SSTATUS.
  - Total sequence length becomes 5 cycles.
- Undefined: state absent, sstatus_value unused, sequence is 4 cycles.

Test Plan:
- Ecall: trap_valid=1, trap=01, trap_pc=0x80000104, stvec_value=0x80000201 -> expected response:
  - cycles 1–3 write (0x141, 0x80000104), (0x142, 8), (0x143, 0);
  - cycle 4 redirect_valid=1, redirect_pc=0x80000200;
  - stall=1 in cycles 1–4.
- Unimp: trap=10, trap_pc=0x80000010, trap_inst=0xC0001073 -> scause write 2, stval write 0x00000000C0001073.
- Ignored requests: trap=11 or trap=00 with trap_valid=1 in IDLE -> no CSR writes, stall stays 0. Second ecall during W_SCAUSE -> ignored, data of the first trap unchanged.
- Reset mid-sequence: rstn=0 asserted in W_SCAUSE -> same cycle stall=0, csr_write=0, trap_ready=1. After release, a new ecall runs the full sequence from W_SEPC.
- Back-to-back: two ecalls (PCs 0x100, 0x200), the second held valid -> second accepted the cycle after the first REDIRECT; sepc writes 0x100 then 0x200.
- With TRAP_SSTATUS_EN: sstatus_value=0x0000000000000002 -> cycle 4 writes (0x100, 0x0000000000000020); redirect in cycle 5.

Source files
------------

// File: rtl/trap_entry_sequencer.sv
// ============================================================================
// trap_entry_sequencer : writes sepc/scause/stval on ecall/unimp, then redirects
// to stvec. Optional macro TRAP_SSTATUS_EN adds an sstatus update step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_entry_sequencer #(
  parameter int XLEN           = 64,
  parameter int SCAUSE_ECALL   = 8,
  parameter int SCAUSE_ILLEGAL = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            trap_valid,
  input  logic [1:0]      trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [31:0]     trap_inst,
  output logic            trap_ready,
  input  logic [XLEN-1:0] stvec_value,
  input  logic [XLEN-1:0] sstatus_value,
  output logic            csr_write,
  output logic [11:0]     csr_write_addr,
  output logic [XLEN-1:0] csr_write_data,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);
  localparam logic [11:0]     CSR_SSTATUS  = 12'h100;
  localparam logic [11:0]     CSR_SEPC     = 12'h141;
  localparam logic [11:0]     CSR_SCAUSE   = 12'h142;
  localparam logic [11:0]     CSR_STVAL    = 12'h143;
  localparam logic [1:0]      TRAP_ECALL   = 2'b01;
  localparam logic [1:0]      TRAP_UNIMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEPC     = 3'd1,
    S_SCAUSE   = 3'd2,
    S_STVAL    = 3'd3,
    S_SSTATUS  = 3'd4,
    S_REDIRECT = 3'd5
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic            accept;
  logic [XLEN-1:0] sstatus_new;

  assign accept = (state == S_IDLE) && trap_valid &&
                  ((trap == TRAP_ECALL) || (trap == TRAP_UNIMP));

`ifdef TRAP_SSTATUS_EN
  // Trap from U-mode: SPIE <- SIE, SIE <- 0, SPP <- 0.
  always_comb begin
    sstatus_new    = sstatus_value;
    sstatus_new[5] = sstatus_value[1];
    sstatus_new[1] = 1'b0;
    sstatus_new[8] = 1'b0;
  end
`else
  logic unused_sstatus;
  assign unused_sstatus = ^sstatus_value;
  assign sstatus_new    = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_SEPC;
            pc_q    <= trap_pc & ALIGN_MASK;
            cause_q <= (trap == TRAP_ECALL) ? XLEN'(SCAUSE_ECALL)
                                            : XLEN'(SCAUSE_ILLEGAL);
            tval_q  <= (trap == TRAP_ECALL) ? '0 : XLEN'(trap_inst);
          end
        end
        S_SEPC:   state <= S_SCAUSE;
        S_SCAUSE: state <= S_STVAL;
`ifdef TRAP_SSTATUS_EN
        S_STVAL:   state <= S_SSTATUS;
        S_SSTATUS: state <= S_REDIRECT;
`else
        S_STVAL:   state <= S_REDIRECT;
`endif
        S_REDIRECT: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; stvec and sstatus are sampled in the cycle they are used.
  always_comb begin
    trap_ready     = (state == S_IDLE);
    stall          = (state != S_IDLE);
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_write_data = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_SEPC: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_SEPC;
        csr_write_data = pc_q;
      end
      S_SCAUSE: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_SCAUSE;
        csr_write_data = cause_q;
      end
      S_STVAL: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_STVAL;
        csr_write_data = tval_q;
      end
`ifdef TRAP_SSTATUS_EN
      S_SSTATUS: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_SSTATUS;
        csr_write_data = sstatus_new;
      end
`endif
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = stvec_value & ALIGN_MASK;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_entry_sequencer.sv
// Randomized + directed bench for trap_entry_sequencer with a cycle-count model.
`default_nettype none

module tb_trap_entry_sequencer;

  localparam int XLEN = 64;
`ifdef TRAP_SSTATUS_EN
  localparam int SEQ_LEN = 5;
`else
  localparam int SEQ_LEN = 4;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            trap_valid;
  logic [1:0]      trap;
  logic [XLEN-1:0] trap_pc;
  logic [31:0]     trap_inst;
  logic            trap_ready;
  logic [XLEN-1:0] stvec_value;
  logic [XLEN-1:0] sstatus_value;
  logic            csr_write;
  logic [11:0]     csr_write_addr;
  logic [XLEN-1:0] csr_write_data;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  trap_entry_sequencer #(.XLEN(XLEN), .SCAUSE_ECALL(8), .SCAUSE_ILLEGAL(2)) dut (
    .clk(clk), .rstn(rstn), .trap_valid(trap_valid), .trap(trap),
    .trap_pc(trap_pc), .trap_inst(trap_inst), .trap_ready(trap_ready),
    .stvec_value(stvec_value), .sstatus_value(sstatus_value),
    .csr_write(csr_write), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: cycles elapsed since acceptance (0 = idle) plus captured values.
  int          step = 0;
  logic [63:0] m_pc = '0, m_cause = '0, m_tval = '0;
  logic [63:0] sepc_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_sstatus(input logic [63:0] s);
    return (s & ~64'h122) | (64'(s[1]) << 5);
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      step = 0; m_pc = '0; m_cause = '0; m_tval = '0;
    end else if (step == 0) begin
      if (trap_valid && (trap == 2'd1 || trap == 2'd2)) begin
        step    = 1;
        m_pc    = trap_pc & ~64'h3;
        m_cause = (trap == 2'd1) ? 64'd8 : 64'd2;
        m_tval  = (trap == 2'd1) ? 64'd0 : {32'd0, trap_inst};
      end
    end else if (step == SEQ_LEN) begin
      step = 0;
    end else begin
      step = step + 1;
    end
  endtask

  task automatic compare();
    logic        ew;
    logic [11:0] ea;
    logic [63:0] ed;
    logic        rv;
    ew = 1'b0; ea = '0; ed = '0;
    case (step)
      1: begin ew = 1'b1; ea = 12'h141; ed = m_pc;    end
      2: begin ew = 1'b1; ea = 12'h142; ed = m_cause; end
      3: begin ew = 1'b1; ea = 12'h143; ed = m_tval;  end
`ifdef TRAP_SSTATUS_EN
      4: begin ew = 1'b1; ea = 12'h100; ed = exp_sstatus(sstatus_value); end
`endif
      default: ;
    endcase
    rv = (step == SEQ_LEN);
    check_eq("trap_ready", 64'(trap_ready), 64'(step == 0));
    check_eq("stall", 64'(stall), 64'(step != 0));
    check_eq("csr_write", 64'(csr_write), 64'(ew));
    check_eq("csr_write_addr", 64'(csr_write_addr), 64'(ea));
    check_eq("csr_write_data", csr_write_data, ed);
    check_eq("redirect_valid", 64'(redirect_valid), 64'(rv));
    check_eq("redirect_pc", redirect_pc, rv ? (stvec_value & ~64'h3) : 64'd0);
    if (csr_write && csr_write_addr == 12'h141) sepc_log.push_back(csr_write_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_trap(input logic v, input logic [1:0] t, input logic [63:0] pc,
                          input logic [31:0] inst);
    trap_valid = v; trap = t; trap_pc = pc; trap_inst = inst;
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    model_edge();
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_csr_write", 64'(csr_write), 64'd0);
    check_eq("rst_trap_ready", 64'(trap_ready), 64'd1);
    compare();
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    set_trap(1'b0, 2'd0, '0, '0);
    stvec_value = '0; sstatus_value = '0;
    repeat (2) @(negedge clk);
    compare();
    check_eq("reset_redirect_pc", redirect_pc, 64'd0);
    rstn = 1'b1;

    // Ecall with known values
    stvec_value = 64'h80000201; sstatus_value = 64'h2;
    set_trap(1'b1, 2'd1, 64'h80000104, 32'h0);
    cycle();
    trap_valid = 1'b0;
    check_eq("ecall_sepc_addr", 64'(csr_write_addr), 64'h141);
    check_eq("ecall_sepc_data", csr_write_data, 64'h80000104);
    cycle();
    check_eq("ecall_scause_data", csr_write_data, 64'd8);
    cycle();
    check_eq("ecall_stval_addr", 64'(csr_write_addr), 64'h143);
    check_eq("ecall_stval_data", csr_write_data, 64'd0);
    cycle();
`ifdef TRAP_SSTATUS_EN
    check_eq("ecall_sstatus_addr", 64'(csr_write_addr), 64'h100);
    check_eq("ecall_sstatus_data", csr_write_data, 64'h20);
    cycle();
`endif
    check_eq("ecall_redirect_valid", 64'(redirect_valid), 64'd1);
    check_eq("ecall_redirect_pc", redirect_pc, 64'h80000200);
    check_eq("ecall_redirect_stall", 64'(stall), 64'd1);
    cycle();
    check_eq("ecall_ready_back", 64'(trap_ready), 64'd1);

    // Unimp
    set_trap(1'b1, 2'd2, 64'h80000010, 32'hC0001073);
    cycle();
    trap_valid = 1'b0;
    cycle();
    check_eq("unimp_scause", csr_write_data, 64'd2);
    cycle();
    check_eq("unimp_stval", csr_write_data, 64'h00000000C0001073);
    repeat (SEQ_LEN - 2) cycle();

    // Ignored requests in IDLE
    set_trap(1'b1, 2'd3, 64'h500, 32'h1);
    cycle();
    check_eq("sret_ignored", 64'(stall), 64'd0);
    trap = 2'd0;
    cycle();
    check_eq("none_ignored", 64'(csr_write), 64'd0);

    // Busy: second ecall during W_SCAUSE is ignored
    set_trap(1'b1, 2'd1, 64'h1000, 32'h0);
    cycle();
    trap_valid = 1'b0;
    cycle();
    set_trap(1'b1, 2'd2, 64'h2000, 32'hDEAD);
    cycle();
    trap_valid = 1'b0;
    check_eq("busy_stval_kept", csr_write_data, 64'd0);
    repeat (SEQ_LEN - 2) cycle();

    // Reset mid-sequence, then a full new sequence
    set_trap(1'b1, 2'd1, 64'h3000, 32'h0);
    cycle();
    trap_valid = 1'b0;
    cycle();
    async_reset();
    set_trap(1'b1, 2'd1, 64'h4003, 32'h0);
    cycle();
    trap_valid = 1'b0;
    check_eq("post_reset_sepc", csr_write_data, 64'h4000);
    repeat (SEQ_LEN) cycle();

    // Back-to-back with second request held valid
    sepc_log.delete();
    set_trap(1'b1, 2'd1, 64'h100, 32'h0);
    cycle();
    trap_pc = 64'h200;
    repeat (SEQ_LEN) cycle();
    check_eq("b2b_idle_gap", 64'(trap_ready), 64'd1);
    cycle();
    trap_valid = 1'b0;
    repeat (SEQ_LEN) cycle();
    check_eq("b2b_sepc_count", 64'(sepc_log.size()), 64'd2);
    if (sepc_log.size() == 2) begin
      check_eq("b2b_sepc0", sepc_log[0], 64'h100);
      check_eq("b2b_sepc1", sepc_log[1], 64'h200);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      trap_valid    = ($urandom_range(0, 2) == 0);
      trap          = 2'($urandom_range(0, 3));
      trap_pc       = {$urandom, $urandom};
      trap_inst     = $urandom;
      stvec_value   = {$urandom, $urandom};
      sstatus_value = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
